// File: rtl/nibble_serial_alu_ctrl.sv
// Nibble-serial sequencer: runs WIDTH-bit operations on an external 4-bit
// combinational ALU, one nibble per clock, LSB nibble first, chaining the
// carry/borrow through the ALU Cin/Cout pins.
//
// ALU control encoding (op[3]=invert A, op[2]=invert B, op[1:0]=function):
//   00 AND, 01 OR, 10 ADD, 11 compare (X[0] = sign ^ overflow).
//   The ALU adds A_in + B_in + Cin, so subtraction relies on this block
//   driving Cin=1 into the least-significant nibble.
// Illegal codes 0011, 1110 and 1111 skip the ALU entirely and report err.
module nibble_serial_alu_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             cout,
    output logic             err,
    output logic             done,
    output logic [3:0]       alu_cont,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic             alu_cin,
    input  logic [3:0]       alu_x,
    input  logic             alu_ov,
    input  logic             alu_cout
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Codes the ALU does not implement.
    function automatic logic op_illegal(input logic [3:0] o);
        return (o == 4'b0011) || (o == 4'b1110) || (o == 4'b1111);
    endfunction

    // Signed compare (lt with A/B as given, gt with A inverted).
    function automatic logic op_compare(input logic [3:0] o);
        return (o[1:0] == 2'b11);
    endfunction

    // Adder-based ops (add, subtract, compare) report overflow/carry.
    function automatic logic op_arith(input logic [3:0] o);
        return o[1];
    endfunction

    // Two's-complement negation of an inverted operand needs the +1 at nibble 0.
    function automatic logic op_first_cin(input logic [3:0] o);
        return o[1] & (o[2] | o[3]);
    endfunction

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q;
    logic [3:0]        op_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic              carry_q;
    logic [WIDTH-1:0]  result_q;
    logic              zero_q, overflow_q, cout_q, err_q;
    logic [WIDTH-1:0]  final_result;
    logic              accept;
    logic              is_last;

    assign ready   = (state_q == S_IDLE);
    assign done    = (state_q == S_DONE);
    assign accept  = start & ready;
    assign is_last = (idx_q == LAST_IDX);

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
    assign cout     = cout_q;
    assign err      = err_q;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: all clocked state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: IDLE -> RUN/DONE on accept, RUN for NIB cycles, DONE for one.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = op_illegal(op) ? S_DONE : S_RUN;
            S_RUN:  if (is_last) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Full-width value formed at the MS nibble edge; compares keep only the lt/gt bit.
    always_comb begin
        final_result = {alu_x, result_q[WIDTH-5:0]};
        if (op_compare(op_q)) final_result = {{(WIDTH-1){1'b0}}, alu_x[0]};
    end

    // Operand/op capture at accept.
    always_ff @(posedge clk) begin
        // NOTE: operand holding registers have no reset; they are only read
        // in RUN, which is always preceded by an accept that loads them.
        if (accept) begin
            op_q <= op;
            a_q  <= a;
            b_q  <= b;
        end
    end

    // Nibble index, carry chain, result and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            cout_q     <= 1'b0;
            err_q      <= 1'b0;
        end else if (accept) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            if (op_illegal(op)) begin
                result_q   <= '0;
                zero_q     <= 1'b1;
                overflow_q <= 1'b0;
                cout_q     <= 1'b0;
                err_q      <= 1'b1;
            end else begin
                err_q <= 1'b0;
            end
        end else if (state_q == S_RUN) begin
            carry_q <= alu_cout;
            if (is_last) begin
                idx_q      <= '0;
                result_q   <= final_result;
                zero_q     <= ~|final_result;
                overflow_q <= op_arith(op_q) & alu_ov;
                cout_q     <= op_arith(op_q) & alu_cout;
            end else begin
                idx_q                          <= idx_q + IW'(1);
                result_q[{idx_q, 2'b00} +: 4] <= alu_x;
            end
        end
    end

    // ALU drive: current nibble, chained carry, subtract code below the MS nibble for compares.
    always_comb begin
        alu_cont = 4'b0000;
        alu_a    = 4'b0000;
        alu_b    = 4'b0000;
        alu_cin  = 1'b0;
        if (state_q == S_RUN) begin
            alu_a    = a_q[{idx_q, 2'b00} +: 4];
            alu_b    = b_q[{idx_q, 2'b00} +: 4];
            alu_cin  = (idx_q == '0) ? op_first_cin(op_q) : carry_q;
            alu_cont = (op_compare(op_q) && !is_last) ? {op_q[3:2], 2'b10} : op_q;
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Scoreboard bench for nibble_serial_alu_ctrl (WIDTH=16) with a behavioural
// 4-bit ALU attached to the alu_* pins. The driver pushes hand-computed
// expectations at accept; the monitor pops and compares on every done pulse.
module tb_nibble_serial_alu_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [3:0]       op = 4'b0000;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             ready, zero, overflow, cout, err, done;
    logic [WIDTH-1:0] result;
    logic [3:0]       alu_cont, alu_a, alu_b, alu_x;
    logic             alu_cin, alu_ov, alu_cout;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] res;
        logic        z;
        logic        ov;
        logic        co;
        logic        er;
        int          lat;
        time         t_acc;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_done = 0;
    int   n_issued = 0;

    nibble_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready), .op(op),
        .a(a), .b(b), .result(result), .zero(zero), .overflow(overflow),
        .cout(cout), .err(err), .done(done), .alu_cont(alu_cont),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_x(alu_x),
        .alu_ov(alu_ov), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    // Behavioural 4-bit ALU: optional A/B inversion, A_in + B_in + Cin adder.
    logic [3:0] m_ai, m_bi;
    logic [4:0] m_sum;
    always_comb begin
        m_ai  = alu_cont[3] ? ~alu_a : alu_a;
        m_bi  = alu_cont[2] ? ~alu_b : alu_b;
        m_sum = {1'b0, m_ai} + {1'b0, m_bi} + {4'b0000, alu_cin};
        alu_ov   = (m_ai[3] == m_bi[3]) && (m_sum[3] != m_ai[3]);
        alu_cout = m_sum[4];
        case (alu_cont[1:0])
            2'b00:   alu_x = m_ai & m_bi;
            2'b01:   alu_x = m_ai | m_bi;
            2'b10:   alu_x = m_sum[3:0];
            default: alu_x = {3'b000, m_sum[3] ^ alu_ov};
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        int   lat;
        if (!rst && done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e   = sb_q.pop_front();
                lat = int'((($time - e.t_acc) - 5) / 10) + 1;
                check($sformatf("result op%b", e.op),   32'(result),   32'(e.res));
                check($sformatf("zero op%b", e.op),     32'(zero),     32'(e.z));
                check($sformatf("overflow op%b", e.op), 32'(overflow), 32'(e.ov));
                check($sformatf("cout op%b", e.op),     32'(cout),     32'(e.co));
                check($sformatf("err op%b", e.op),      32'(err),      32'(e.er));
                check($sformatf("latency op%b", e.op),  32'(lat),      32'(e.lat));
            end
        end
    end

    // Wait (bounded) for ready, present one request, push its expectation at the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] r, input logic z, input logic ov,
                         input logic co, input logic er, input bit track);
        exp_t e;
        int   w;
        w = 0;
        @(negedge clk);
        while (!ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_issue", 32'(ready), 32'd1);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        e.op    = o;
        e.res   = r;
        e.z     = z;
        e.ov    = ov;
        e.co    = co;
        e.er    = er;
        e.lat   = er ? 1 : 5;
        e.t_acc = $time;
        if (track) begin
            sb_q.push_back(e);
            n_issued++;
        end
        #1 start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready",    32'(ready),    32'd1);
        check("reset_done",     32'(done),     32'd0);
        check("reset_result",   32'(result),   32'd0);
        check("reset_zero",     32'(zero),     32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_cout",     32'(cout),     32'd0);
        check("reset_err",      32'(err),      32'd0);
        rst = 1'b0;

        // Add, then hammer start while busy: every request must be ignored.
        issue(4'b0010, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("busy_ready_%0d", i), 32'(ready), 32'd0);
            start = 1'b1;
            op    = 4'b0001;
            a     = 16'hFFFF;
            b     = 16'hFFFF;
        end
        @(posedge clk);
        #1 start = 1'b0;

        // Subtract: signed overflow with carry, and equal operands giving zero.
        issue(4'b0110, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        issue(4'b0110, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        // Signed less-than; probe the ALU pins on nibble 0 (subtract code, Cin=1).
        issue(4'b0111, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("nib0_alu_cont", 32'(alu_cont), 32'h6);
        check("nib0_alu_cin",  32'(alu_cin),  32'd1);
        check("nib0_alu_a",    32'(alu_a),    32'hF);
        check("nib0_alu_b",    32'(alu_b),    32'h1);

        // Signed greater-than across the sign boundary, and a false less-than.
        issue(4'b1011, 16'h7FFF, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        issue(4'b0111, 16'h0005, 16'h0003, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        // Logic ops: flags forced to zero even when the adder would carry.
        issue(4'b1100, 16'hF0F0, 16'h0FF0, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(4'b0000, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(4'b0001, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Add boundaries: positive overflow, and full wrap to zero with carry.
        issue(4'b0010, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(4'b0010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        // Illegal codes: single-edge turnaround, zero result, err set.
        issue(4'b1110, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        issue(4'b1111, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        issue(4'b0011, 16'h1234, 16'h0FFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of RUN (idx 2); that op must never complete.
        issue(4'b0010, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrun_rst_ready",    32'(ready),    32'd1);
        check("midrun_rst_done",     32'(done),     32'd0);
        check("midrun_rst_result",   32'(result),   32'd0);
        check("midrun_rst_zero",     32'(zero),     32'd0);
        check("midrun_rst_overflow", 32'(overflow), 32'd0);
        check("midrun_rst_cout",     32'(cout),     32'd0);
        check("midrun_rst_err",      32'(err),      32'd0);
        check("midrun_rst_alu_a",    32'(alu_a),    32'd0);
        check("midrun_rst_alu_cont", 32'(alu_cont), 32'd0);
        rst = 1'b0;

        // Reverse subtract (b - a) after the reset.
        issue(4'b1010, 16'h0001, 16'h0005, 16'h0004, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        w = 0;
        while (sb_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(n_issued));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
